// File: rtl/centroid_ctrl_if.sv
// Signal bundle between the centroid frame sequencer and its environment:
// video timing, accumulator pair, and the shared divider.
interface centroid_ctrl_if #(
  parameter int POS_W = 11,
  parameter int ACC_W = 30,
  parameter int CNT_W = 21
);
    logic             de;
    logic             v_sync;
    logic             mask;
    logic             acc_ce;
    logic             acc_clr;
    logic [POS_W-1:0] acc_x;
    logic [POS_W-1:0] acc_y;
    logic [ACC_W-1:0] m10_sum;
    logic [ACC_W-1:0] m01_sum;
    logic             div_start;
    logic [ACC_W-1:0] div_dividend;
    logic [CNT_W-1:0] div_divisor;
    logic             div_done;
    logic [POS_W-1:0] div_quot;
    logic [POS_W-1:0] x_c;
    logic [POS_W-1:0] y_c;
    logic             c_valid;
    logic             empty;
    logic             overrun;

    modport master (
        input  de, v_sync, mask, m10_sum, m01_sum, div_done, div_quot,
        output acc_ce, acc_clr, acc_x, acc_y, div_start, div_dividend, div_divisor,
               x_c, y_c, c_valid, empty, overrun
    );

    modport slave (
        output de, v_sync, mask, m10_sum, m01_sum, div_done, div_quot,
        input  acc_ce, acc_clr, acc_x, acc_y, div_start, div_dividend, div_divisor,
               x_c, y_c, c_valid, empty, overrun
    );
endinterface

// File: rtl/centroid_ctrl.sv
// Frame-level centroid sequencer: pixel position generation, mask-gated moment
// accumulation, end-of-frame snapshot and two divisions on a shared divider.
module centroid_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int POS_W    = 11,
  parameter int ACC_W    = 30,
  parameter int CNT_W    = 21
) (
    input logic            clk,
    input logic            rst,
    centroid_ctrl_if.master bus
);

    localparam logic [2:0] SYNC = 3'd0;
    localparam logic [2:0] IDLE = 3'd1;
    localparam logic [2:0] CHK  = 3'd2;
    localparam logic [2:0] DX   = 3'd3;
    localparam logic [2:0] DY   = 3'd4;
    localparam logic [2:0] OUT  = 3'd5;

    localparam logic [POS_W:0] H_LIM = (POS_W+1)'(H_ACTIVE);
    localparam logic [POS_W:0] V_LIM = (POS_W+1)'(V_ACTIVE);

    function automatic logic [POS_W-1:0] sat_inc_pos(input logic [POS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2:0]       state;
    logic             de_p1;
    logic             vs_p1;
    logic             vs_p2;
    logic             vs_rise;
    logic             snap_p3;
    logic             acc_clr_r;
    logic [POS_W-1:0] x_cnt;
    logic [POS_W-1:0] y_cnt;
    logic [CNT_W-1:0] m00;
    logic [ACC_W-1:0] m10_snap;
    logic [ACC_W-1:0] m01_snap;
    logic [CNT_W-1:0] m00_snap;
    logic [POS_W-1:0] quot_x;
    logic [POS_W-1:0] x_c_r;
    logic [POS_W-1:0] y_c_r;
    logic             empty_r;
    logic             div_start_r;
    logic             accumulating;
    logic             pix_hit;

    assign vs_rise      = vs_p1 & ~vs_p2;
    assign accumulating = (state != SYNC);
    assign pix_hit      = bus.de & bus.mask & accumulating &
                          ({1'b0, x_cnt} < H_LIM) & ({1'b0, y_cnt} < V_LIM);

    assign bus.acc_ce       = pix_hit;
    assign bus.acc_x        = x_cnt;
    assign bus.acc_y        = y_cnt;
    assign bus.acc_clr      = acc_clr_r;
    assign bus.div_start    = div_start_r;
    assign bus.div_dividend = (state == DY) ? m01_snap : m10_snap;
    assign bus.div_divisor  = m00_snap;
    assign bus.x_c          = x_c_r;
    assign bus.y_c          = y_c_r;
    assign bus.c_valid      = (state == OUT);
    assign bus.empty        = (state == OUT) & empty_r;
    // A frame end is dropped whenever the sequencer is still busy with the previous one.
    assign bus.overrun      = snap_p3 & (state != IDLE) & (state != SYNC);

    // p1: timing registers; p2/p3: late v_sync edge and snapshot strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            de_p1     <= 1'b0;
            vs_p1     <= 1'b0;
            vs_p2     <= 1'b0;
            snap_p3   <= 1'b0;
            acc_clr_r <= 1'b1;
            x_cnt     <= '0;
            y_cnt     <= '0;
            m00       <= '0;
        end else begin
            de_p1     <= bus.de;
            vs_p1     <= bus.v_sync;
            vs_p2     <= vs_p1;
            snap_p3   <= vs_rise;
            acc_clr_r <= vs_rise;
            if (bus.de)
                x_cnt <= sat_inc_pos(x_cnt);
            else if (de_p1)
                x_cnt <= '0;
            if (vs_rise)
                y_cnt <= '0;
            else if (de_p1 && !bus.de)
                y_cnt <= sat_inc_pos(y_cnt);
            if (snap_p3)
                m00 <= '0;
            else if (pix_hit)
                m00 <= sat_inc_cnt(m00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SYNC;
            m10_snap    <= '0;
            m01_snap    <= '0;
            m00_snap    <= '0;
            quot_x      <= '0;
            x_c_r       <= '0;
            y_c_r       <= '0;
            empty_r     <= 1'b0;
            div_start_r <= 1'b0;
        end else begin
            div_start_r <= 1'b0;
            case (state)
                SYNC: if (snap_p3) state <= IDLE;
                IDLE: begin
                    if (snap_p3) begin
                        m10_snap <= bus.m10_sum;
                        m01_snap <= bus.m01_sum;
                        m00_snap <= m00;
                        state    <= CHK;
                    end
                end
                CHK: begin
                    if (m00_snap == '0) begin
                        x_c_r   <= '0;
                        y_c_r   <= '0;
                        empty_r <= 1'b1;
                        state   <= OUT;
                    end else begin
                        div_start_r <= 1'b1;
                        state       <= DX;
                    end
                end
                DX: begin
                    if (bus.div_done) begin
                        quot_x      <= bus.div_quot;
                        div_start_r <= 1'b1;
                        state       <= DY;
                    end
                end
                // Results are published together so x_c/y_c only change at c_valid.
                DY: begin
                    if (bus.div_done) begin
                        x_c_r   <= quot_x;
                        y_c_r   <= bus.div_quot;
                        empty_r <= 1'b0;
                        state   <= OUT;
                    end
                end
                OUT:     state <= IDLE;
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_ctrl.sv
// Directed bench for centroid_ctrl on an 8x4 active window with a 3-cycle divider.
module tb_centroid_ctrl;

    localparam int H       = 8;
    localparam int V       = 4;
    localparam int POS_W   = 11;
    localparam int ACC_W   = 30;
    localparam int CNT_W   = 21;
    localparam int DIV_LAT = 3;

    typedef struct {
        int x;
        int y;
        int e;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    centroid_ctrl_if #(.POS_W(POS_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    centroid_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .POS_W(POS_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    bit   armed = 1'b0;
    bit   hold = 1'b0;
    int   sx = 0;
    int   sy = 0;
    int   vs_count = 0;
    int   n_valid = 0;
    int   n_start = 0;
    int   n_ovr = 0;
    int   n_clr = 0;
    int   cap_x = -1;
    int   cap_y = -1;
    int   cap_e = -1;
    int   last_rst = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pix(input int mode, input int x, input int y);
        case (mode)
            0:       return (x == 5) && (y == 2);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return (x == 9) || (y == 5) || (x == 1 && y == 1) || (x == 6 && y == 3);
        endcase
    endfunction

    task automatic vsync();
        bus.v_sync = 1'b1;
        repeat (3) tick();
        bus.v_sync = 1'b0;
        repeat (8) tick();
        vs_count++;
    endtask

    // Drives one frame; the expected centroid is the mean of in-window mask pixels.
    task automatic run_frame(input int mode, input bit push);
        int np, nl, n;
        longint s10, s01;
        res_t r;
        np = (mode == 3) ? 10 : H;
        nl = (mode == 3) ? 6 : V;
        n = 0; s10 = 0; s01 = 0;
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < np; x++) begin
                bus.de = 1'b1;
                bus.mask = pix(mode, x, y);
                sx = x;
                sy = y;
                if (armed && bus.mask && x < H && y < V) begin
                    n++;
                    s10 += x;
                    s01 += y;
                end
                tick();
            end
            bus.de = 1'b0;
            bus.mask = 1'b0;
            repeat (4) tick();
        end
        if (push) begin
            r.x = (n == 0) ? 0 : int'(s10 / n);
            r.y = (n == 0) ? 0 : int'(s01 / n);
            r.e = (n == 0) ? 1 : 0;
            exp_q.push_back(r);
        end
        vsync();
    endtask

    // External m10/m01 accumulator pair
    initial begin
        forever begin
            @(posedge clk);
            if (bus.acc_clr === 1'b1) begin
                bus.m10_sum <= '0;
                bus.m01_sum <= '0;
            end else if (bus.acc_ce === 1'b1) begin
                bus.m10_sum <= bus.m10_sum + ACC_W'(bus.acc_x);
                bus.m01_sum <= bus.m01_sum + ACC_W'(bus.acc_y);
            end
        end
    end

    // Shared divider; 'hold' stalls the pending result
    initial begin
        logic [ACC_W-1:0] dd;
        logic [CNT_W-1:0] dv;
        int dcnt;
        dcnt = 0;
        dd = '0;
        dv = '0;
        forever begin
            @(posedge clk);
            bus.div_done <= 1'b0;
            if (bus.div_start === 1'b1) begin
                dd = bus.div_dividend;
                dv = bus.div_divisor;
                dcnt = DIV_LAT - 1;
            end else if (dcnt == 1) begin
                if (!hold) begin
                    bus.div_done <= 1'b1;
                    bus.div_quot <= POS_W'((dv == 0) ? 0 : dd / dv);
                    dcnt = 0;
                end
            end else if (dcnt > 1) begin
                dcnt = dcnt - 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            last_rst <= rst ? 2 : 1;
        end
    end

    // Per-cycle compare against the behavioural model
    initial begin
        bit exp_ce;
        bit cbusy;
        logic [ACC_W-1:0] cdd;
        logic [CNT_W-1:0] cdv;
        res_t r;
        cbusy = 1'b0;
        cdd = '0;
        cdv = '0;
        forever begin
            @(negedge clk);
            if (last_rst == 1) begin
                check("rst_acc_clr", bus.acc_clr, 1);
                check("rst_acc_ce", bus.acc_ce, 0);
                check("rst_c_valid", bus.c_valid, 0);
                check("rst_x_c", bus.x_c, 0);
                check("rst_y_c", bus.y_c, 0);
                check("rst_div_start", bus.div_start, 0);
                check("rst_overrun", bus.overrun, 0);
                check("rst_empty", bus.empty, 0);
                cbusy = 1'b0;
            end else if (last_rst == 2) begin
                exp_ce = bus.de && bus.mask && sx < H && sy < V && armed;
                check("acc_ce", bus.acc_ce, exp_ce);
                if (exp_ce) begin
                    check("acc_x", bus.acc_x, sx);
                    check("acc_y", bus.acc_y, sy);
                end
                if (bus.c_valid) begin
                    n_valid++;
                    cap_x = int'(bus.x_c);
                    cap_y = int'(bus.y_c);
                    cap_e = int'(bus.empty);
                    check("c_valid_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        r = exp_q.pop_front();
                        check("x_c", bus.x_c, r.x);
                        check("y_c", bus.y_c, r.y);
                        check("empty", bus.empty, r.e);
                    end
                end else begin
                    check("empty_without_valid", bus.empty, 0);
                end
                if (bus.overrun) n_ovr++;
                if (bus.acc_clr) n_clr++;
                if (bus.div_start) begin
                    n_start++;
                    check("start_while_busy", cbusy, 0);
                    cdd = bus.div_dividend;
                    cdv = bus.div_divisor;
                    cbusy = 1'b1;
                end else if (cbusy) begin
                    check("dividend_stable", bus.div_dividend, cdd);
                    check("divisor_stable", bus.div_divisor, cdv);
                    if (bus.div_done) cbusy = 1'b0;
                end
            end
        end
    end

    initial begin
        int v0, s0, o0;
        bus.de = 1'b0;
        bus.v_sync = 1'b0;
        bus.mask = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        vsync();
        armed = 1'b1;

        // single pixel at (5,2)
        v0 = n_valid;
        run_frame(0, 1'b1);
        repeat (30) tick();
        check("t1_valid_count", n_valid - v0, 1);
        check("t1_x", cap_x, 5);
        check("t1_y", cap_y, 2);
        check("t1_empty", cap_e, 0);

        // full window: 112/32, 48/32
        s0 = n_start;
        run_frame(1, 1'b1);
        repeat (30) tick();
        check("t2_x", cap_x, 3);
        check("t2_y", cap_y, 1);
        check("t2_div_starts", n_start - s0, 2);

        // empty frame
        s0 = n_start;
        v0 = n_valid;
        run_frame(2, 1'b1);
        repeat (30) tick();
        check("t3_valid_count", n_valid - v0, 1);
        check("t3_empty", cap_e, 1);
        check("t3_x", cap_x, 0);
        check("t3_y", cap_y, 0);
        check("t3_div_starts", n_start - s0, 0);

        // out-of-window pixels ignored: (1,1),(6,3) -> (3,2)
        run_frame(3, 1'b1);
        repeat (30) tick();
        check("t4_x", cap_x, 3);
        check("t4_y", cap_y, 2);

        // divider stalled across the next frame end
        o0 = n_ovr;
        v0 = n_valid;
        hold = 1'b1;
        run_frame(0, 1'b1);
        run_frame(1, 1'b0);
        repeat (10) tick();
        hold = 1'b0;
        repeat (30) tick();
        check("t5_overrun_count", n_ovr - o0, 1);
        check("t5_valid_count", n_valid - v0, 1);
        check("t5_x", cap_x, 5);
        check("t5_y", cap_y, 2);

        // reset while a division is outstanding
        v0 = n_valid;
        s0 = n_start;
        hold = 1'b1;
        run_frame(1, 1'b0);
        for (int i = 0; i < 40 && n_start == s0; i++) tick();
        check("t6_start_seen", n_start - s0, 1);
        rst = 1'b0;
        armed = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        hold = 1'b0;
        repeat (20) tick();
        run_frame(0, 1'b0);
        armed = 1'b1;
        run_frame(1, 1'b1);
        repeat (30) tick();
        check("t6_valid_count", n_valid - v0, 1);
        check("t6_x", cap_x, 3);
        check("t6_y", cap_y, 1);

        check("queue_drained", exp_q.size(), 0);
        check("acc_clr_pulses", n_clr, vs_count);
        check("overrun_total", n_ovr, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/centroid_ctrl.md
Name: centroid_ctrl

Overview:
Frame-level sequencer for the centroid datapath. It generates pixel x/y positions from the video timing and gates the m10/m01 accumulator pair with the binary mask. It counts the m00 pixel total internally. At end of frame it snapshots the moments and clears the accumulators. It then schedules two divisions (m10/m00, m01/m00) on one shared external divider and presents the centroid with a valid pulse.

Parameters:
H_ACTIVE, 1280, active pixels per line; x positions >= H_ACTIVE are never accumulated
V_ACTIVE, 720, active lines per frame; y positions >= V_ACTIVE are never accumulated
POS_W, 11, position width
ACC_W, 30, m10/m01 accumulator width
CNT_W, 21, m00 pixel counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
de  in  1  data enable; high during active pixels
v_sync  in  1  vertical sync, active-high; rising edge marks end of frame
mask  in  1  binary object pixel, qualified by de
acc_ce  out  1  accumulator clock enable (both accumulators)
acc_clr  out  1  accumulator reset, active-high, one-cycle pulse
acc_x  out  POS_W  x position to m10 accumulator
acc_y  out  POS_W  y position to m01 accumulator
m10_sum  in  ACC_W  m10 accumulator output (registered)
m01_sum  in  ACC_W  m01 accumulator output (registered)
div_start  out  1  divider request, one-cycle pulse
div_dividend  out  ACC_W  dividend, stable from div_start until div_done
div_divisor  out  CNT_W  divisor, stable from div_start until div_done
div_done  in  1  divider result valid, one-cycle pulse
div_quot  in  POS_W  quotient
x_c  out  POS_W  centroid x
y_c  out  POS_W  centroid y
c_valid  out  1  one-cycle pulse; x_c/y_c are valid and held until the next pulse
empty  out  1  high with c_valid when m00 == 0
overrun  out  1  one-cycle pulse when a frame end is dropped

Behaviour:
- Reset (rst==0 at posedge): state=SYNC. All outputs 0 except acc_clr=1. x/y counters=0, m00=0, snapshot registers=0.
- Position counters:
  - x increments on each de cycle and clears on the de falling edge.
  - y increments on the de falling edge and clears on the v_sync rising edge.
  - Neither counter wraps: both saturate at 2^POS_W-1.
- acc_ce = de & mask & (x<H_ACTIVE) & (y<V_ACTIVE) & accumulating. It is combinational, aligned with acc_x/acc_y.
- m00 increments under the same condition and saturates at 2^CNT_W-1.
- Frame-end detection: v_sync registered; rising edge detected one cycle late.
- Accumulation runs in every state except SYNC. Frame capture and clearing are independent of the divider FSM.
- Capture sequence on a frame end:
  - The cycle after detection (SNAP), m10_sum, m01_sum and m00 are copied into snapshot registers. This one-cycle delay absorbs the accumulator register stage.
  - In the same cycle acc_clr=1 and m00 is cleared.
  - If the divider FSM is not in IDLE at SNAP, the snapshot is NOT taken, the accumulators are still cleared, and overrun pulses for 1 cycle.
- FSM states:
  - SYNC: wait for the first v_sync rising edge; no accumulation; then clear the accumulators and go to IDLE. No c_valid is issued for the partial first frame.
  - IDLE: on SNAP, go to CHK.
  - CHK: if m00_snap==0, go to OUT with x_c=0, y_c=0, empty=1. Else go to DX, with div_start=1, dividend=m10_snap, divisor=m00_snap.
  - DX: wait for div_done; latch x_c=div_quot; issue div_start with dividend=m01_snap; go to DY.
  - DY: wait for div_done; latch y_c=div_quot; go to OUT.
  - OUT: c_valid=1, empty as computed, for 1 cycle; go to IDLE.
- div_start is never asserted while a division is outstanding. A div_done arriving in IDLE/CHK/OUT is ignored.
- Latency from SNAP to c_valid: 2 + divider latency×2 + 2 cycles.
- Simultaneous events:
  - A v_sync edge in the same cycle as OUT counts as overrun; the FSM is not yet in IDLE.
  - A de pixel in the same cycle as acc_clr is lost; this is legal because the snapshot occurs in blanking.
- Reset mid-division: the FSM returns to SYNC, and any pending div_done is ignored. x_c, y_c, c_valid, empty and overrun are cleared.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4; single mask pixel at (5,2); divider returning after 3 cycles -> one c_valid, x_c=5, y_c=2, empty=0.
- Same geometry, mask=1 everywhere -> m10=112, m01=48, m00=32 -> x_c=3, y_c=1; exactly 2 div_start pulses; operands stable until each div_done.
- Mask all 0 -> c_valid with empty=1, x_c=0, y_c=0; no div_start.
- Divider holds div_done low across the next frame's v_sync -> overrun pulse once, acc_clr still pulses, only the first frame's result is produced.
- mask=1 at x=9 with H_ACTIVE=8, and on line y=5 with V_ACTIVE=4 -> acc_ce stays 0; centroid equals the in-bounds pixels only.
- rst low during DX, then released -> no c_valid until a full frame following the next v_sync edge; stray div_done ignored.
